// File: rtl/coherence_bus_ctrl_if.sv
// Cache-side and RAM-side signal bundle seen by the coherence bus controller.
// The slave modport is the controller's view; master is the caches/RAM side.
interface coherence_bus_ctrl_if #(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]      iREN;
    logic [32*CPUS-1:0]   iaddr;
    logic [CPUS-1:0]      iwait;
    logic [32*CPUS-1:0]   iload;
    logic [CPUS-1:0]      dREN;
    logic [CPUS-1:0]      dWEN;
    logic [CPUS-1:0]      cctrans;
    logic [CPUS-1:0]      ccwrite;
    logic [32*CPUS-1:0]   daddr;
    logic [32*CPUS-1:0]   dstore;
    logic [CPUS-1:0]      dwait;
    logic [32*CPUS-1:0]   dload;
    logic [CPUS-1:0]      ccwait;
    logic [CPUS-1:0]      ccinv;
    logic [32*CPUS-1:0]   ccsnoopaddr;
    logic                 ramREN;
    logic                 ramWEN;
    logic [31:0]          ramaddr;
    logic [31:0]          ramstore;
    logic [31:0]          ramload;
    logic [1:0]           ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core bus/coherence controller: arbitrates icache/dcache requests onto one
// RAM port and runs snoop, invalidate and cache-to-cache transfers between dcaches.
module coherence_bus_ctrl #(
    parameter int CPUS         = 2,
    parameter int BLOCK_WORDS  = 2,
    parameter int SNOOP_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    coherence_bus_ctrl_if.slave  bus
);
    localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int SW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_WORD  = CW'(BLOCK_WORDS - 1);
    localparam logic [SW-1:0] LAST_SNOOP = SW'(SNOOP_CYCLES - 1);
    localparam logic [1:0]    RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DWB    = 3'd2,
        SNOOP  = 3'd3,
        C2C    = 3'd4,
        RAMLD  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;
    logic [SW-1:0]   snoop_cnt_q, snoop_cnt_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;

    logic [CPUS-1:0]    req_dwb_s, req_snp_s, req_any_s;
    logic               pick_s, other_s, access_s;
    logic [5:0]         g_off_s, o_off_s;
    logic [CPUS-1:0]    iwait_s, dwait_s, ccwait_s, ccinv_s;
    logic [32*CPUS-1:0] iload_s, dload_s, ccsnoop_s;
    logic               ram_ren_s, ram_wen_s;
    logic [31:0]        ram_addr_s, ram_store_s;

    // Per-core request classification and round-robin pick
    always_comb begin
        for (int i = 0; i < CPUS; i++) begin
            req_dwb_s[i] = bus.dWEN[i] & ~bus.cctrans[i];
            req_snp_s[i] = bus.cctrans[i] & (bus.dREN[i] | bus.ccwrite[i]);
            req_any_s[i] = req_dwb_s[i] | req_snp_s[i] | bus.iREN[i];
        end
        if (&req_any_s) begin
            pick_s = ~last_grant_q;
        end else begin
            pick_s = req_any_s[1];
        end
        other_s  = ~grant_q;
        g_off_s  = {grant_q, 5'd0};
        o_off_s  = {other_s, 5'd0};
        access_s = (bus.ramstate == RAM_ACCESS);
    end

    // Next-state and output decode; a dropped request returns to IDLE with counters cleared
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        snoop_cnt_d  = snoop_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        iwait_s      = '1;
        dwait_s      = '1;
        ccwait_s     = '0;
        ccinv_s      = '0;
        iload_s      = '0;
        dload_s      = '0;
        ccsnoop_s    = '0;
        ram_ren_s    = 1'b0;
        ram_wen_s    = 1'b0;
        ram_addr_s   = 32'd0;
        ram_store_s  = 32'd0;
        case (state_q)
            IDLE: begin
                if (|req_any_s) begin
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    if (req_dwb_s[pick_s]) begin
                        state_d = DWB;
                    end else if (req_snp_s[pick_s]) begin
                        state_d = SNOOP;
                    end else begin
                        state_d = IFETCH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            IFETCH: begin
                ram_ren_s             = 1'b1;
                ram_addr_s            = bus.iaddr[g_off_s +: 32];
                iload_s[g_off_s +: 32] = bus.ramload;
                if (!bus.iREN[grant_q]) begin
                    state_d    = IDLE;
                    word_cnt_d = '0;
                end else if (access_s) begin
                    iwait_s[grant_q] = 1'b0;
                    state_d          = IDLE;
                end else begin
                    state_d = IFETCH;
                end
            end
            DWB: begin
                ram_wen_s   = 1'b1;
                ram_addr_s  = bus.daddr[g_off_s +: 32];
                ram_store_s = bus.dstore[g_off_s +: 32];
                if (!bus.dREN[grant_q] && !bus.dWEN[grant_q]) begin
                    state_d    = IDLE;
                    word_cnt_d = '0;
                end else if (access_s) begin
                    dwait_s[grant_q] = 1'b0;
                    state_d          = IDLE;
                end else begin
                    state_d = DWB;
                end
            end
            SNOOP: begin
                ccwait_s[other_s]        = 1'b1;
                ccinv_s[other_s]         = bus.ccwrite[grant_q];
                ccsnoop_s[o_off_s +: 32] = bus.daddr[g_off_s +: 32];
                if (!bus.cctrans[grant_q]) begin
                    state_d     = IDLE;
                    snoop_cnt_d = '0;
                    word_cnt_d  = '0;
                end else if (snoop_cnt_q == LAST_SNOOP) begin
                    snoop_cnt_d = '0;
                    // Upgrade needs only the invalidate; the requester already has the data
                    if (bus.ccwrite[grant_q] && !bus.dREN[grant_q]) begin
                        dwait_s[grant_q] = 1'b0;
                        state_d          = IDLE;
                    end else if (bus.cctrans[other_s] && bus.dWEN[other_s]) begin
                        state_d = C2C;
                    end else begin
                        state_d = RAMLD;
                    end
                end else begin
                    snoop_cnt_d = snoop_cnt_q + SW'(1);
                end
            end
            C2C: begin
                ccwait_s[other_s]      = 1'b1;
                ram_wen_s              = 1'b1;
                ram_addr_s             = bus.daddr[o_off_s +: 32];
                ram_store_s            = bus.dstore[o_off_s +: 32];
                dload_s[g_off_s +: 32] = bus.dstore[o_off_s +: 32];
                if (!bus.dREN[grant_q] && !bus.dWEN[grant_q]) begin
                    state_d    = IDLE;
                    word_cnt_d = '0;
                end else if (access_s) begin
                    dwait_s[grant_q] = 1'b0;
                    dwait_s[other_s] = 1'b0;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = C2C;
                end
            end
            RAMLD: begin
                ram_ren_s              = 1'b1;
                ram_addr_s             = bus.daddr[g_off_s +: 32];
                dload_s[g_off_s +: 32] = bus.ramload;
                if (!bus.dREN[grant_q] && !bus.dWEN[grant_q]) begin
                    state_d    = IDLE;
                    word_cnt_d = '0;
                end else if (access_s) begin
                    dwait_s[grant_q] = 1'b0;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = RAMLD;
                end
            end
            default: begin
                state_d     = IDLE;
                word_cnt_d  = '0;
                snoop_cnt_d = '0;
            end
        endcase
    end

    // State, counters and arbitration history
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            snoop_cnt_q  <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            snoop_cnt_q  <= snoop_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.iwait       = iwait_s;
    assign bus.iload       = iload_s;
    assign bus.dwait       = dwait_s;
    assign bus.dload       = dload_s;
    assign bus.ccwait      = ccwait_s;
    assign bus.ccinv       = ccinv_s;
    assign bus.ccsnoopaddr = ccsnoop_s;
    assign bus.ramREN      = ram_ren_s;
    assign bus.ramWEN      = ram_wen_s;
    assign bus.ramaddr     = ram_addr_s;
    assign bus.ramstore    = ram_store_s;
endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
Bus and coherence controller that consumes the per-cache signal bundles of two CPUs, each with one icache and one dcache. It arbitrates them onto the single RAM port and runs the snoop/invalidate protocol between the two dcaches. It sits directly downstream of the cache-side interface and upstream of the RAM model. It also performs cache-to-cache transfers, writing the supplied block back to RAM at the same time.

Parameters:
CPUS, 2, number of cores; only 2 is supported.
BLOCK_WORDS, 2, words per dcache block transferred on a miss.
SNOOP_CYCLES, 2, cycles the snoop request is held before the response is sampled.

Ports:
CLK  input  1  clock; all state changes on its rising edge.
nRST  input  1  asynchronous active-low reset.
iREN  input  CPUS  icache read request, one bit per CPU.
iaddr  input  32*CPUS  icache address; CPU i uses bits [32i+31:32i].
iwait  output  CPUS  low for exactly the cycle iload is valid.
iload  output  32*CPUS  instruction data.
dREN, dWEN, cctrans, ccwrite  input  CPUS  dcache request and coherence flags.
daddr, dstore  input  32*CPUS  dcache address and write data.
dwait  output  CPUS  low for the cycle a dcache word completes.
dload  output  32*CPUS  dcache read data.
ccwait, ccinv  output  CPUS  snoop stall and invalidate command to the snooped cache.
ccsnoopaddr  output  32*CPUS  snoop address.
ramREN, ramWEN  output  1  RAM read and write enables.
ramaddr, ramstore  output  32  RAM address and write data.
ramload  input  32  RAM read data.
ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR. ERROR is treated as BUSY.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; word count=0; snoop count=0; last_grant=1, so CPU0 wins first.
  - iwait=dwait='1; ccwait=ccinv='0; ramREN=ramWEN=0.
  - All data and address outputs = 0.
- All outputs not named below hold their idle value: wait bits=1, all enables=0.
- States: IDLE, IFETCH, DWB, SNOOP, C2C, RAMLD.
- Arbitration in IDLE:
  - Pick the CPU with any request; if both request, pick the one that is not last_grant.
  - last_grant updates on every grant.
  - Within the chosen CPU g, priority is:
    - dWEN & ~cctrans → DWB
    - cctrans & (dREN | ccwrite) → SNOOP
    - iREN → IFETCH
  - An IDLE cycle always costs 1 cycle before the grant.
- IFETCH:
  - Drive ramREN=1, ramaddr=iaddr[g], iload[g]=ramload.
  - On ramstate==ACCESS: iwait[g]=0, then next state=IDLE.
- DWB (plain writeback, one word):
  - Drive ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - On ACCESS: dwait[g]=0, then next state=IDLE.
- SNOOP, with o = the other CPU:
  - Drive ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g] for SNOOP_CYCLES cycles.
  - On the last snoop cycle, sample the responder:
    - ccwrite[g] & ~dREN[g] (S→M upgrade): dwait[g]=0 in that cycle, next state=IDLE, no RAM access.
    - cctrans[o] & dWEN[o] (responder holds the block Modified): next state=C2C.
    - Otherwise: next state=RAMLD.
- C2C:
  - Hold ccwait[o]=1.
  - Drive ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[g]=dstore[o].
  - On ACCESS: dwait[g]=dwait[o]=0 in the same cycle, and the word count increments.
  - After BLOCK_WORDS words: count=0, next state=IDLE.
- RAMLD:
  - Drive ramREN=1, ramaddr=daddr[g], dload[g]=ramload.
  - On ACCESS: dwait[g]=0, count increments; after BLOCK_WORDS words, next state=IDLE.
  - Each word uses the daddr presented in that cycle; the cache increments the address.
- Abort: if the granted request drops mid-transaction (e.g. dREN[g] and dWEN[g] both 0 in RAMLD/DWB, or iREN[g]=0 in IFETCH):
  - Next state=IDLE.
  - Counters clear.
  - No wait bit is lowered.
- Each wait bit is low for at most 1 cycle per ACCESS cycle.
- RAM enables are never asserted outside IFETCH, DWB, C2C and RAMLD.
- A new request arriving during a transaction is ignored until IDLE.
- Word count is 1 bit wide and wraps 1→0 on completion.

Test Plan:
- Icache fetch: iREN[0]=1, iaddr0=0x40; ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF → ramREN=1, ramaddr=0x40; iwait[0]=0 for 1 cycle with iload0=0xDEADBEEF; back to IDLE.
- Fairness: iREN=2'b11 held continuously → grants alternate CPU0, CPU1, CPU0, with iwait pulses in that order and one IDLE cycle between grants.
- RAM miss: CPU0 dREN=1, cctrans=1, ccwrite=0, daddr=0x100; CPU1 does not supply → ccwait[1]=1 and ccsnoopaddr1=0x100 for 2 cycles with ccinv[1]=0; then RAM reads 0x100 and 0x104; dwait[0] pulses twice.
- Cache-to-cache: same request as the RAM miss, but CPU1 asserts cctrans=1, dWEN=1, dstore=0xAAAA5555, daddr=0x100 → ramWEN to 0x100; dload0=0xAAAA5555; dwait[0] and dwait[1] low in the same cycle, for 2 words.
- Upgrade: CPU0 ccwrite=1, cctrans=1, dREN=0, daddr=0x200 → ccinv[1]=1 for 2 cycles; dwait[0]=0 in the 2nd cycle; no ramREN/ramWEN.
- Reset mid-C2C: drive nRST=0 asynchronously during the 1st word → all outputs take their reset values before the next edge; after release, the first grant goes to CPU0.
